// File: rtl/mem_ctrl.sv
// mem_ctrl: responder for the LSB call/respond memory protocol and the
// instruction-fetch port. Arbitrates between the two clients (LSB first) and
// serialises each 1/2/4-byte access onto the byte-wide RAM/IO bus, one byte
// per cycle. Read data is returned zero-extended above the access length.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes every register
//   rollback            misprediction flush (aborts fetches and LSB reads)
//   call_*              LSB request (valid, is_store, addr, len, data)
//   respond_valid/data  LSB completion pulse and load data
//   if_valid/if_addr    fetch request (always 4 bytes)
//   if_ready/if_data    fetch completion pulse and instruction word
//   mem_din/dout/a/wr   byte-wide RAM/IO bus; read byte arrives one cycle late
//   io_buffer_full      UART full; stalls LSB stores to the IO window
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        call_valid,
  input  logic        call_is_store,
  input  logic [31:0] call_addr,
  input  logic [2:0]  call_len,
  input  logic [31:0] call_data,
  output logic        respond_valid,
  output logic [31:0] respond_data,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  localparam int unsigned ADDR_WID   = 32;
  localparam int unsigned DATA_WID   = 32;
  localparam int unsigned ST_LEN_WID = 3;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [ST_LEN_WID-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic [1:0]            lane;
  logic [ADDR_WID-1:0]   base_q, base_d, mem_a_d;
  logic [DATA_WID-1:0]   data_q, data_d, buf_q, buf_d, rd_merge;
  logic [DATA_WID-1:0]   respond_data_d, if_data_d;
  logic                  fetch_q, fetch_d;
  logic [7:0]            mem_dout_d, wr_byte;
  logic                  mem_wr_d, respond_valid_d, if_ready_d;
  logic                  io_stall_c;

  // Byte on mem_din belongs to the address issued one cycle earlier (cnt-1).
  assign cnt_inc  = cnt_q + ST_LEN_WID'(1);
  assign lane     = 2'(cnt_q - ST_LEN_WID'(1));
  assign rd_merge = buf_q | (DATA_WID'(mem_din) << {lane, 3'b000});
  assign wr_byte  = 8'(data_q >> {cnt_inc[1:0], 3'b000});

  // Stores into the IO window wait while the UART buffer is full.
  assign io_stall_c = call_is_store && (call_addr[17:16] == 2'b11) && io_buffer_full;

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    len_d           = len_q;
    base_d          = base_q;
    data_d          = data_q;
    fetch_d         = fetch_q;
    buf_d           = buf_q;
    mem_a_d         = mem_a;
    mem_dout_d      = mem_dout;
    mem_wr_d        = mem_wr;
    respond_valid_d = 1'b0;
    respond_data_d  = respond_data;
    if_ready_d      = 1'b0;
    if_data_d       = if_data;

    case (state_q)
      IDLE: begin
        // A pending LSB request (even a stalled one) blocks the fetch.
        if (!rollback && call_valid && !io_stall_c) begin
          state_d    = call_is_store ? WRITE : READ;
          base_d     = call_addr;
          len_d      = call_len;
          data_d     = call_data;
          fetch_d    = 1'b0;
          cnt_d      = '0;
          buf_d      = '0;
          mem_a_d    = call_addr;
          mem_wr_d   = call_is_store;
          mem_dout_d = call_is_store ? call_data[7:0] : 8'h00;
        end else if (!rollback && !call_valid && if_valid) begin
          state_d    = READ;
          base_d     = if_addr;
          len_d      = ST_LEN_WID'(4);
          data_d     = '0;
          fetch_d    = 1'b1;
          cnt_d      = '0;
          buf_d      = '0;
          mem_a_d    = if_addr;
          mem_wr_d   = 1'b0;
          mem_dout_d = 8'h00;
        end
      end

      READ: begin
        if (rollback) begin
          state_d  = IDLE;
          cnt_d    = '0;
          mem_a_d  = '0;
          mem_wr_d = 1'b0;
        end else begin
          if (cnt_q != '0) buf_d = rd_merge;
          if (cnt_q == len_q) begin
            // Final byte is on mem_din now; publish the assembled word.
            state_d = DONE;
            cnt_d   = '0;
            mem_a_d = '0;
            if (fetch_q) begin
              if_ready_d = 1'b1;
              if_data_d  = rd_merge;
            end else begin
              respond_valid_d = 1'b1;
              respond_data_d  = rd_merge;
            end
          end else begin
            cnt_d   = cnt_inc;
            mem_a_d = (cnt_inc < len_q) ? base_q + ADDR_WID'(cnt_inc) : '0;
          end
        end
      end

      WRITE: begin
        // Stores are never aborted by rollback.
        if (cnt_inc < len_q) begin
          cnt_d      = cnt_inc;
          mem_a_d    = base_q + ADDR_WID'(cnt_inc);
          mem_dout_d = wr_byte;
        end else begin
          state_d         = DONE;
          cnt_d           = '0;
          mem_a_d         = '0;
          mem_dout_d      = 8'h00;
          mem_wr_d        = 1'b0;
          respond_valid_d = 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; rst wins over rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      len_q         <= '0;
      base_q        <= '0;
      data_q        <= '0;
      fetch_q       <= 1'b0;
      buf_q         <= '0;
      mem_a         <= '0;
      mem_dout      <= 8'h00;
      mem_wr        <= 1'b0;
      respond_valid <= 1'b0;
      respond_data  <= '0;
      if_ready      <= 1'b0;
      if_data       <= '0;
    end else if (rdy) begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      base_q        <= base_d;
      data_q        <= data_d;
      fetch_q       <= fetch_d;
      buf_q         <= buf_d;
      mem_a         <= mem_a_d;
      mem_dout      <= mem_dout_d;
      mem_wr        <= mem_wr_d;
      respond_valid <= respond_valid_d;
      respond_data  <= respond_data_d;
      if_ready      <= if_ready_d;
      if_data       <= if_data_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed steps plus randomized transactions checked
// against a byte-addressed reference memory and the access timing rules.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        call_valid, call_is_store;
  logic [31:0] call_addr, call_data;
  logic [2:0]  call_len;
  logic        respond_valid;
  logic [31:0] respond_data;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int errors = 0;
  int checks = 0;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .call_valid(call_valid), .call_is_store(call_is_store),
    .call_addr(call_addr), .call_len(call_len), .call_data(call_data),
    .respond_valid(respond_valid), .respond_data(respond_data),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // Power-on contents; 0x100..0x103 hold 11 22 33 44.
  function automatic logic [7:0] pat(input logic [31:0] a);
    return 8'((32'(a[7:0]) + 32'd1) * 32'd17) ^ a[15:8] ^ a[31:24] ^ 8'h01;
  endfunction

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : pat(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction

  // External RAM: same enable domain as the controller, one-cycle read latency.
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a] = mem_dout;
      mem_din <= env_rd(mem_a);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction from acceptance to the idle cycle after the response.
  // frz_at: real cycle where rdy drops for 3 cycles; rb_at: rollback cycle.
  task automatic txn(input bit fe, input bit st, input logic [31:0] a, input int n,
                     input logic [31:0] d, input int frz_at, input int rb_at);
    logic [31:0] exp_d;
    int exp_lat, lg, seen;
    exp_d = '0;
    for (int i = 0; i < n; i++) exp_d[8*i +: 8] = ref_rd(a + 32'(i));
    if (st) for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
    exp_lat = st ? n + 1 : n + 2;
    if (frz_at > 0) exp_lat += 3;
    if (fe) begin
      if_valid = 1'b1;
      if_addr  = a;
    end else begin
      call_valid    = 1'b1;
      call_is_store = st;
      call_addr     = a;
      call_len      = 3'(n);
      call_data     = d;
    end
    seen = 0;
    for (int r = 1; r <= 40 && seen == 0; r++) begin
      tick();
      lg = (frz_at > 0 && r > frz_at) ? ((r - 3 < frz_at) ? frz_at : r - 3) : r;
      if (lg >= 1 && lg <= n) begin
        check("mem_a", mem_a, a + 32'(lg - 1));
        check("mem_wr", 32'(mem_wr), 32'(st));
        if (st) check("mem_dout", 32'(mem_dout), 32'(d[8*(lg-1) +: 8]));
      end else begin
        check("mem_wr_off", 32'(mem_wr), 32'd0);
        if (!st && lg == n + 1) check("mem_a_tail", mem_a, 32'd0);
      end
      check("other_pulse", 32'(fe ? respond_valid : if_ready), 32'd0);
      if (fe ? if_ready : respond_valid) begin
        seen = r;
        check("latency", 32'(r), 32'(exp_lat));
        if (!st) check("rdata", fe ? if_data : respond_data, exp_d);
      end
      rdy      = !(frz_at > 0 && r >= frz_at && r < frz_at + 3);
      rollback = (r == rb_at);
    end
    if (seen == 0) check("no_response", 32'(seen), 32'(exp_lat));
    tick();
    rollback   = 1'b0;
    rdy        = 1'b1;
    if_valid   = 1'b0;
    call_valid = 1'b0;
    check("pulse_low", 32'(respond_valid | if_ready), 32'd0);
    if (!st) check("hold", fe ? if_data : respond_data, exp_d);
  endtask

  initial begin
    logic [31:0] exp_lh, exp_if;
    int rv, ir;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    call_valid = 1'b0; call_is_store = 1'b0; call_addr = '0; call_len = '0; call_data = '0;
    if_valid = 1'b0; if_addr = '0; io_buffer_full = 1'b0;
    repeat (3) tick();
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_respond", 32'(respond_valid | if_ready), 32'd0);
    check("rst_rdata", respond_data | if_data, 32'd0);
    rst = 1'b0;
    tick();

    // LW at 0x100
    txn(0, 0, 32'h100, 4, 32'h0, 0, 0);
    check("lw_const", respond_data, 32'h44332211);

    // SB then LB
    txn(0, 1, 32'h205, 1, 32'hFFFF_FF80, 0, 0);
    txn(0, 0, 32'h205, 1, 32'h0, 0, 0);
    check("lb_const", respond_data, 32'h0000_0080);

    // Simultaneous LSB LH and fetch: LSB first, fetch after DONE
    exp_lh = {16'h0, ref_rd(32'h11), ref_rd(32'h10)};
    exp_if = {ref_rd(32'h3), ref_rd(32'h2), ref_rd(32'h1), ref_rd(32'h0)};
    call_valid = 1'b1; call_is_store = 1'b0; call_addr = 32'h10; call_len = 3'd2;
    if_valid = 1'b1; if_addr = 32'h0;
    rv = 0; ir = 0;
    for (int r = 1; r <= 30 && ir == 0; r++) begin
      tick();
      check("coincide", 32'(respond_valid & if_ready), 32'd0);
      if (respond_valid) begin
        rv = r;
        check("sim_lsb_lat", 32'(r), 32'd4);
        check("sim_lsb_data", respond_data, exp_lh);
      end
      if (if_ready) begin
        ir = r;
        check("sim_if_lat", 32'(r), 32'd11);
        check("sim_if_data", if_data, exp_if);
      end
      if (rv != 0 && r == rv + 1) call_valid = 1'b0;
    end
    if (ir == 0) check("sim_if_timeout", 32'(ir), 32'd11);
    tick();
    if_valid = 1'b0; call_valid = 1'b0;

    // Rollback in cycle 2 of a fetch
    if_valid = 1'b1; if_addr = 32'h400;
    tick();
    tick();
    rollback = 1'b1; if_valid = 1'b0;
    tick();
    rollback = 1'b0;
    check("rb_fetch_mem_a", mem_a, 32'd0);
    check("rb_fetch_ready", 32'(if_ready), 32'd0);
    txn(0, 0, 32'h104, 2, 32'h0, 0, 0);

    // Rollback in cycle 2 of a SW, then read it back
    txn(0, 1, 32'h300, 4, 32'hDEAD_BEEF, 0, 2);
    txn(0, 0, 32'h300, 4, 32'h0, 0, 0);
    check("rb_sw_readback", respond_data, 32'hDEAD_BEEF);

    // Rollback while idle blocks acceptance for that cycle
    call_valid = 1'b1; call_is_store = 1'b0; call_addr = 32'h120; call_len = 3'd4;
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    check("rb_idle_mem_a", mem_a, 32'd0);
    txn(0, 0, 32'h120, 4, 32'h0, 0, 0);

    // IO-write stall with a pending fetch
    call_valid = 1'b1; call_is_store = 1'b1; call_addr = 32'h3_0000; call_len = 3'd1;
    call_data = 32'hA5; io_buffer_full = 1'b1;
    if_valid = 1'b1; if_addr = 32'h500;
    for (int r = 1; r <= 5; r++) begin
      tick();
      check("io_stall_wr", 32'(mem_wr), 32'd0);
      check("io_stall_a", mem_a, 32'd0);
      check("io_stall_ifr", 32'(if_ready), 32'd0);
    end
    io_buffer_full = 1'b0;
    if_valid = 1'b1;
    txn(0, 1, 32'h3_0000, 1, 32'hA5, 0, 0);
    txn(1, 0, 32'h500, 4, 32'h0, 0, 0);

    // Freeze mid-LW and address wrap-around
    txn(0, 0, 32'h100, 4, 32'h0, 3, 0);
    txn(0, 0, 32'hFFFF_FFFE, 4, 32'h0, 0, 0);
    txn(1, 0, 32'hFFFF_FFFF, 4, 32'h0, 0, 0);

    // Randomized mix of fetches, loads and stores
    for (int it = 0; it < 30; it++) begin
      int kind, n, frz, rb;
      logic [31:0] a, d;
      kind = int'($urandom_range(0, 2));
      n    = (kind == 0) ? 4 : (1 << $urandom_range(0, 2));
      a    = 32'h1000 + 32'($urandom_range(0, 47));
      d    = $urandom;
      frz  = 0;
      rb   = 0;
      if ($urandom_range(0, 3) == 0) frz = int'($urandom_range(1, (kind == 2) ? n : n + 1));
      if (kind == 2 && $urandom_range(0, 2) == 0) rb = int'($urandom_range(1, n));
      txn(kind == 0, kind == 2, a, n, d, frz, rb);
    end

    // Reset mid-access, with rdy low to show reset still wins
    call_valid = 1'b1; call_is_store = 1'b0; call_addr = 32'h140; call_len = 3'd4;
    tick();
    tick();
    rst = 1'b1; rdy = 1'b0;
    tick();
    check("rst_mid_mem_a", mem_a, 32'd0);
    check("rst_mid_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mid_pulses", 32'(respond_valid | if_ready), 32'd0);
    check("rst_mid_respond_data", respond_data, 32'd0);
    check("rst_mid_if_data", if_data, 32'd0);
    rst = 1'b0; rdy = 1'b1; call_valid = 1'b0;
    tick();
    txn(0, 0, 32'h140, 4, 32'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller: the responder side of the LSB `call_*`/`respond_*` memory protocol and of the instruction-fetch request port. It arbitrates between the two clients and serialises each 1/2/4-byte access onto the byte-wide RAM/IO bus, one byte per cycle. It returns zero-extended read data; sign extension stays in the LSB. It sits between the LSB and the instruction fetcher on one side and the external RAM/IO bus on the other.

## Interface
- Parameters: none; widths come from `const.v` (`ADDR_WID`=32, `DATA_WID`=32, `ST_LEN_WID`=3).
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `rdy`  in  1  global enable; low freezes every register.
- `rollback`  in  1  misprediction flush.
- `call_valid`, `call_is_store`  in  1  LSB request; held high until the response is taken.
- `call_addr`  in  32  LSB address.
- `call_len`  in  3  LSB access length: 1, 2 or 4 bytes.
- `call_data`  in  32  store data, little-endian.
- `respond_valid`  out  1  one-cycle pulse: LSB access done.
- `respond_data`  out  32  load data, zero-extended above `call_len` bytes.
- `if_valid`  in  1  fetch request; held high until answered.
- `if_addr`  in  32  fetch address; access is always 4 bytes.
- `if_ready`  out  1  one-cycle pulse: fetch done.
- `if_data`  out  32  instruction word.
- `mem_din`  in  8  RAM read byte; valid one cycle after its address.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  32  RAM/IO byte address.
- `mem_wr`  out  1  1 = write.
- `io_buffer_full`  in  1  UART buffer full.

## Operation
- States: IDLE, READ, WRITE, DONE. Reset or rollback abort leads to IDLE. On reset: all outputs 0, byte counter 0.
- **Acceptance (IDLE only).**
  - LSB has priority over fetch when both are valid.
  - Latch the address, length, store data, client ID (LSB or fetch) and counter `cnt`=0.
- **IO-write stall.** An LSB store with `call_addr[17:16]==2'b11` is not accepted while `io_buffer_full`=1. Fetch cannot overtake a stalled LSB request.
- **READ, length n.**
  - `mem_a` = base+`cnt`, `mem_wr`=0, `cnt` increments each cycle.
  - The byte arriving on `mem_din` is stored to lane (`cnt`−1).
  - Once the last address is issued, `mem_a`=0 for one cycle while the final byte returns.
  - Then raise `respond_valid` or `if_ready` and go to DONE.
- **WRITE, length n.**
  - `mem_a` = base+`cnt`, `mem_dout` = byte `cnt` of the data, `mem_wr`=1 for n cycles.
  - Then `mem_wr`=0, raise `respond_valid`, go to DONE.
- **DONE.** Lasts exactly one cycle, during which the client's valid is still high. No acceptance in DONE; go to IDLE.
- **Response outputs.**
  - `respond_valid` and `if_ready` are single-cycle pulses, never both high at once.
  - `respond_data` and `if_data` hold their value until the next response to that client.
  - Bytes above n are 0.
- **Rollback** (when `rdy`=1):
  - Aborts any fetch, queued or in progress.
  - Aborts an in-progress LSB read: to IDLE, `mem_wr`=0, no response.
  - An in-progress LSB write continues to completion and still responds.
  - DONE completes normally.
  - In IDLE under rollback, nothing is accepted that cycle.
- `rst` overrides everything, including `rdy`=0.

## Timing
- All outputs are registered.
- Accept edge E0. Read of n bytes: `mem_a` carries bytes 0..n−1 in cycles 1..n; `respond_valid`/`if_ready` high in cycle n+2 (4-byte fetch: cycle 6). Idle again in cycle n+3.
- Write of n bytes: `mem_wr`=1 in cycles 1..n; `respond_valid` high in cycle n+1.
- Back-to-back: the next request can be accepted at the end of the cycle after the response pulse. Minimum idle gap: 1 cycle.
- Address arithmetic is 32-bit wrap-around (0xFFFFFFFF+1 = 0).
- `rdy`=0 mid-access: `cnt` and outputs hold, and `mem_wr` keeps its value. The sequence resumes unchanged when `rdy` returns.

## Test plan
- **LW.** LSB load, addr 0x100, len 4, RAM bytes 11 22 33 44 → `mem_a` 0x100..0x103 in cycles 1-4; `respond_valid` in cycle 6 with `respond_data`=0x44332211.
- **SB then LB.** SB addr 0x205 data 0xFFFFFF80 → single write, byte 0x80, `respond_valid` in cycle 2. A following LB at 0x205 returns 0x00000080.
- **Simultaneous requests.** `if_valid`, addr 0x0, and LSB LH at 0x10 in the same cycle → LSB served first; fetch accepted the cycle after DONE. `if_ready` and `respond_valid` never coincide.
- **Rollback.**
  - Rollback in cycle 2 of a fetch → no `if_ready`, state IDLE next cycle.
  - Rollback in cycle 2 of a SW → all 4 bytes written, `respond_valid` still pulses.
- **IO stall.** SB to 0x30000 with `io_buffer_full`=1 for 5 cycles → no `mem_wr` until the cycle after it drops; a pending fetch stays blocked.
- **Freeze and reset.** `rdy` low for 3 cycles mid-LW → response delayed exactly 3 cycles with the same data. `rst` mid-access → all outputs 0 next cycle.
